alu_issue_ctrl: RTL

- Initiator/sequencer side of the 8-bit four-op ALU (ADD/SUB/MUL/DIV, 2-bit op, 8-bit operands, combinational result).
- Accepts one thread's request on a valid/ready handshake from the core, registers the operands and drives them onto the ALU.
- Waits a per-op number of cycles so the deep MUL/DIV paths settle, captures the result, and returns it on a valid/ready response channel with the request tag.

---
 rtl/alu_issue_pkg.sv | 22 ++
 rtl/alu_settle_cnt.sv | 27 ++
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared opcodes, FSM state type and constants for the ALU issue controller.
package alu_issue_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [7:0] DIV0_RESULT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // {N,Z,P} of a byte read as signed 8-bit.
   function automatic logic [2:0] nzp_of(input logic [7:0] d);
      return {d[7], (d == 8'h00), (!d[7] && (d != 8'h00))};
   endfunction

endpackage

// File: rtl/alu_settle_cnt.sv
// Loadable down-counter with a zero flag; paces the ALU settle time.
module alu_settle_cnt #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 8-bit four-op ALU: request handshake, per-op settle wait, response channel.
// Optional macro ALU_ISSUE_NZP_EN adds the registered rsp_nzp flags output.
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int unsigned TAG_W      = 2,
   parameter int unsigned ADD_CYCLES = 1,
   parameter int unsigned SUB_CYCLES = 1,
   parameter int unsigned MUL_CYCLES = 2,
   parameter int unsigned DIV_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [7:0]       req_rs,
   input  logic [7:0]       req_rt,
   input  logic [1:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   output logic [7:0]       alu_rs,
   output logic [7:0]       alu_rt,
   output logic [1:0]       alu_op,
   input  logic [7:0]       alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_div0
`ifdef ALU_ISSUE_NZP_EN
   ,
   output logic [2:0]       rsp_nzp
`endif
);

   localparam int unsigned MAX_AS  = (ADD_CYCLES > SUB_CYCLES) ? ADD_CYCLES : SUB_CYCLES;
   localparam int unsigned MAX_MD  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_AS > MAX_MD) ? MAX_AS : MAX_MD;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   function automatic logic [CNT_W-1:0] cycles_m1(input logic [1:0] op);
      case (op)
         OP_ADD:  return CNT_W'(ADD_CYCLES - 1);
         OP_SUB:  return CNT_W'(SUB_CYCLES - 1);
         OP_MUL:  return CNT_W'(MUL_CYCLES - 1);
         default: return CNT_W'(DIV_CYCLES - 1);
      endcase
   endfunction

   state_t           state, state_nxt;
   logic             accept;
   logic             capture;
   logic             req_div0;
   logic             div0_pend;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_load_val;
   logic [7:0]       result_nxt;

   assign req_div0     = (req_op == OP_DIV) && (req_rt == 8'h00);
   // Divide-by-zero still spends one EXEC cycle so its response lands at T+1 like a 1-cycle op.
   assign cnt_load_val = req_div0 ? '0 : cycles_m1(req_op);
   assign result_nxt   = div0_pend ? DIV0_RESULT : alu_result;
   assign rsp_valid    = (state == RESP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: req_ready = 1'b1;
         EXEC: begin
            if (cnt_zero) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            req_ready = rsp_ready;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      accept = req_valid && req_ready;
      if (accept) state_nxt = EXEC;
   end

   alu_settle_cnt #(
      .W (CNT_W)
   ) u_settle_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (cnt_load_val),
      .dec      (state == EXEC),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_rs    <= '0;
         alu_rt    <= '0;
         alu_op    <= '0;
         rsp_tag   <= '0;
         rsp_data  <= '0;
         rsp_div0  <= 1'b0;
         div0_pend <= 1'b0;
      end else begin
         if (accept) begin
            alu_rs    <= req_rs;
            alu_rt    <= req_rt;
            alu_op    <= req_op;
            rsp_tag   <= req_tag;
            div0_pend <= req_div0;
         end
         if (capture) begin
            rsp_data <= result_nxt;
            rsp_div0 <= div0_pend;
         end
      end
   end

`ifdef ALU_ISSUE_NZP_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_nzp <= '0;
      end else if (capture) begin
         rsp_nzp <= nzp_of(result_nxt);
      end
   end
`endif

endmodule
